// File: rtl/dmac_req_sequencer_pkg.sv
// dmac_req_sequencer_pkg: FSM states, AHB encodings and datapath mux selects shared by the sequencer
package dmac_req_sequencer_pkg;
  typedef enum logic [3:0] {
    S_IDLE,
    S_BUSREQ,
    S_CFG_ADDR,
    S_CFG_DATA,
    S_START,
    S_XFER,
    S_DONE,
    S_RELEASE,
    S_ABORT
  } state_e;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] CONSEL_CH1    = 2'b00;
  localparam logic [1:0] CONSEL_CH2    = 2'b01;
  localparam logic [1:0] CONSEL_CFG    = 2'b10;
  localparam int         CFG_WORDS     = 4;
endpackage

// File: rtl/dmac_req_sequencer_if.sv
// dmac_req_sequencer_if: peripheral, AHB-master and datapath-control signals of the request sequencer
interface dmac_req_sequencer_if;
  logic [1:0] DmacReq;
  logic       HGrant;
  logic       HReady;
  logic [1:0] M_HResp;
  logic       irq;
  logic       C_config;
  logic       HBusReq;
  logic       DmacReq_Reg_en;
  logic       PeriAddr_reg_en;
  logic [1:0] addr_inc_sel;
  logic [1:0] config_HTrans;
  logic       config_write;
  logic       SAddr_Reg_en;
  logic       DAddr_Reg_en;
  logic       Trans_sz_Reg_en;
  logic       Ctrl_Reg_en;
  logic [1:0] con_sel;
  logic       con_en;
  logic       channel_en_1;
  logic       channel_en_2;
  logic [1:0] DmacAck;
  logic       busy;
  logic       err;
  modport master (
    input  DmacReq, HGrant, HReady, M_HResp, irq, C_config,
    output HBusReq, DmacReq_Reg_en, PeriAddr_reg_en, addr_inc_sel, config_HTrans, config_write,
           SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en, Ctrl_Reg_en, con_sel, con_en,
           channel_en_1, channel_en_2, DmacAck, busy, err
  );
  modport slave (
    output DmacReq, HGrant, HReady, M_HResp, irq, C_config,
    input  HBusReq, DmacReq_Reg_en, PeriAddr_reg_en, addr_inc_sel, config_HTrans, config_write,
           SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en, Ctrl_Reg_en, con_sel, con_en,
           channel_en_1, channel_en_2, DmacAck, busy, err
  );
endinterface

// File: rtl/dmac_req_sequencer_arbiter.sv
// dmac_req_arbiter: fixed-priority pick (req[1] over req[0]) held as the served requester for a whole service
module dmac_req_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       load_i,
  output logic [1:0] srv_o
);
  logic [1:0] gnt, srv_q, srv_d;
  assign gnt   = req_i[1] ? 2'b10 : {1'b0, req_i[0]};
  assign srv_d = load_i ? gnt : srv_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) srv_q <= 2'b00;
    else     srv_q <= srv_d;
  assign srv_o = srv_q;
endmodule

// File: rtl/dmac_req_sequencer.sv
// dmac_req_sequencer: arbitrates peripheral requests, fetches the 4-word descriptor and runs one DMAC channel
module dmac_req_sequencer
  import dmac_req_sequencer_pkg::*;
#(
  parameter int TMO_W = 10
) (
  input logic                  clk,
  input logic                  rst,
  dmac_req_sequencer_if.master bus
);
  localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] WD_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  state_e           state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic [TMO_W-1:0] wd_q, wd_d;
  logic             ch_q, ch_d, con_en_q, con_en_d;
  logic [1:0]       srv;
  logic             start_req, rd_ok;
  // rst gate keeps the Mealy latch enables quiet while reset is held with a request pending
  assign start_req = state_q == S_IDLE && |bus.DmacReq && !rst;
  assign rd_ok     = state_q == S_CFG_DATA && bus.HReady && bus.M_HResp == HRESP_OKAY;
  dmac_req_arbiter u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_i  (bus.DmacReq),
    .load_i (start_req),
    .srv_o  (srv)
  );
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wd_d    = wd_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE:     if (start_req) state_d = S_BUSREQ;
      S_BUSREQ:   if (bus.HGrant) begin
        state_d = S_CFG_ADDR;
        k_d     = 2'd0;
      end
      S_CFG_ADDR: begin
        wd_d = '0;
        if (bus.HReady) state_d = S_CFG_DATA;
      end
      S_CFG_DATA: if (bus.HReady) begin
        if (bus.M_HResp != HRESP_OKAY) state_d = S_ABORT;
        else if (k_q == 2'(CFG_WORDS - 1)) state_d = S_START;
        else begin
          k_d     = k_q + 2'd1;
          state_d = S_CFG_ADDR;
        end
      end else if (wd_q == WD_LAST) state_d = S_ABORT;
      else wd_d = wd_q + WD_ONE;
      // Ctrl is cleared by the datapath on irq, so the channel choice is kept here
      S_START: begin
        ch_d    = bus.C_config;
        state_d = S_XFER;
      end
      S_XFER:     if (bus.irq) state_d = S_DONE;
        else if (bus.HReady && bus.M_HResp == HRESP_ERROR) state_d = S_ABORT;
      S_DONE, S_ABORT: state_d = S_RELEASE;
      S_RELEASE:  if ((bus.DmacReq & srv) == 2'b00) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    con_en_d = state_d == S_START || state_d == S_DONE || state_d == S_ABORT ||
               (state_q == S_BUSREQ && state_d == S_CFG_ADDR);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= 2'd0;
      wd_q     <= '0;
      ch_q     <= 1'b0;
      con_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wd_q     <= wd_d;
      ch_q     <= ch_d;
      con_en_q <= con_en_d;
    end
  assign bus.HBusReq         = state_q inside {S_BUSREQ, S_CFG_ADDR, S_CFG_DATA, S_START, S_XFER};
  assign bus.DmacReq_Reg_en  = start_req;
  assign bus.PeriAddr_reg_en = start_req;
  assign bus.addr_inc_sel    = state_q inside {S_CFG_ADDR, S_CFG_DATA} ? k_q : 2'd0;
  assign bus.config_HTrans   = state_q == S_CFG_ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.config_write    = 1'b0;
  assign bus.SAddr_Reg_en    = rd_ok && k_q == 2'd0;
  assign bus.DAddr_Reg_en    = rd_ok && k_q == 2'd1;
  assign bus.Trans_sz_Reg_en = rd_ok && k_q == 2'd2;
  assign bus.Ctrl_Reg_en     = rd_ok && k_q == 2'd3;
  assign bus.con_sel         = state_q == S_START ? (bus.C_config ? CONSEL_CH2 : CONSEL_CH1) :
                               state_q == S_XFER  ? (ch_q ? CONSEL_CH2 : CONSEL_CH1) : CONSEL_CFG;
  assign bus.con_en          = con_en_q;
  assign bus.channel_en_1    = state_q == S_XFER && !ch_q;
  assign bus.channel_en_2    = state_q == S_XFER && ch_q;
  assign bus.DmacAck         = state_q inside {S_DONE, S_ABORT} ? srv : 2'b00;
  assign bus.busy            = state_q != S_IDLE;
  assign bus.err             = state_q == S_ABORT;
endmodule
